mem_readback: RTL and testbench
===============================

Name: mem_readback

Overview:
Read-side counterpart of the FPGA program/data loader. The loader writes words into the shared RAM through the data-port mux; this block takes the same mux (bus_enable, mem_addr) and reads back a window of RAM one word at a time. It shows each word on the board displays, so the result memory can be inspected after the CPU stops. While it owns the bus, the CPU is held off with cpu_enable low.

Parameters:
BASE_ADDR, 32'h0000_0400, byte address of the first word in the window (word aligned)
N_WORDS, 16, number of 32-bit words in the window (2..256)
IDX_W, 8, width of word_index; must satisfy 2^IDX_W >= N_WORDS

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
start_btn  input  1  raw pushbutton: begin readback (asynchronous, debounced upstream)
next_btn  input  1  raw pushbutton: advance to the next word
prev_btn  input  1  raw pushbutton: go back to the previous word
exit_btn  input  1  raw pushbutton: release the bus and return to IDLE
mem_data_in  input  32  RAM data_out (memload); synchronous RAM, data valid 1 cycle after the address
bus_enable  output  1  selects mem_addr onto the RAM data-port mux
mem_addr  output  32  byte address to RAM
cpu_enable  output  1  PC advance enable to the CPU
word_value  output  32  last word captured, for the seven-segment drivers
word_index  output  IDX_W  index of word_value within the window
valid  output  1  word_value/word_index are current
busy  output  1  high in every state except IDLE

Behaviour:
Reset values (async, nrst low): state IDLE, bus_enable=0, mem_addr=BASE_ADDR, cpu_enable=1, word_value=0, word_index=0, valid=0, busy=0.

Button conditioning:
- Each button passes through a 2-FF synchronizer, then a rising-edge detector.
- The result is a 1-cycle pulse per press.
- Holding a button gives one pulse only.

FSM:
- IDLE: bus_enable=0, cpu_enable=1. On start pulse: word_index<=0, mem_addr<=BASE_ADDR, bus_enable<=1, cpu_enable<=0, go to ADDR.
- ADDR: address stable on the bus, valid=0. Next cycle go to CAPT.
- CAPT: word_value<=mem_data_in, valid<=1, go to SHOW. Latency from entering ADDR to valid=1 is exactly 2 clocks.
- SHOW: hold word_value and keep the bus.
  - next pulse: if word_index==N_WORDS-1, wrap to index 0 and mem_addr=BASE_ADDR; else index+1 and mem_addr+4. Then valid<=0 and go to ADDR.
  - prev pulse: if word_index==0, wrap to N_WORDS-1 and mem_addr=BASE_ADDR+4*(N_WORDS-1); else index-1 and mem_addr-4. Then valid<=0 and go to ADDR.
  - next and prev in the same cycle: both ignored, stay in SHOW.
  - exit pulse: go to IDLE with bus_enable=0, cpu_enable=1, valid=0. word_value and word_index are retained.

Priority and boundary rules:
- exit has priority over next/prev in any non-IDLE state. In ADDR/CAPT it aborts with no capture.
- start, next and prev in ADDR/CAPT are dropped, not queued.
- start outside IDLE is ignored.
- Address arithmetic is 32-bit. mem_addr always stays within [BASE_ADDR, BASE_ADDR+4*(N_WORDS-1)].
- The block never drives a write. The top level ties the write-enable mux input to 0 when bus_enable=1.
- Reset mid-readback: all outputs return to reset values immediately. The CPU is re-enabled.

Optional Feature:
AUTO_SCAN_EN.
- Defined: adds parameter SCAN_TICKS (default 50_000_000) and a free-running counter active in SHOW only.
  - When the counter reaches SCAN_TICKS-1, it acts as a next pulse (same wrap rules) and resets to 0.
  - Any next/prev pulse also resets the counter to 0.
  - The counter is 0 on entry to SHOW.
- Not defined: no counter. SHOW advances only on button pulses.

Test Plan:
- Preload RAM words 0x100..0x10F (bytes 0x400..0x43C) with 0xA5000000+i; reset; start pulse -> bus_enable=1 and cpu_enable=0 one cycle after the edge-detect pulse; valid=1 two cycles later with word_value=0xA5000000, word_index=0.
- From SHOW index 0, next x3 -> word_index=3, mem_addr=0x40C, word_value=0xA5000003. Each step drops valid for exactly 2 cycles.
- At index 0, prev pulse -> wrap to word_index=15, mem_addr=0x43C, word_value=0xA500000F. From 15, next -> index 0, mem_addr=0x400.
- next and prev pulsed in the same cycle in SHOW -> no change. next held high for 100 cycles -> exactly one advance.
- exit asserted in the cycle after start (ADDR) -> IDLE, bus_enable=0, cpu_enable=1, valid=0, word_value unchanged. nrst pulsed low mid-SHOW -> all outputs at reset values asynchronously.
- AUTO_SCAN_EN with SCAN_TICKS=8 -> in SHOW, index advances every 8+2 cycles and wraps 15->0. A next pulse at tick 5 restarts the count.

Source files
------------

// File: rtl/mem_readback.sv
// Debug readback of a RAM window through the loader's data-port mux, one word per button press.
// Optional feature macro AUTO_SCAN_EN adds a SHOW-state timer that auto-advances every SCAN_TICKS cycles.
module mem_readback #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          N_WORDS   = 16,
  parameter int          IDX_W     = 8
`ifdef AUTO_SCAN_EN
  , parameter int        SCAN_TICKS = 50_000_000
`endif
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_btn,
  input  logic             next_btn,
  input  logic             prev_btn,
  input  logic             exit_btn,
  input  logic [31:0]      mem_data_in,
  output logic             bus_enable,
  output logic [31:0]      mem_addr,
  output logic             cpu_enable,
  output logic [31:0]      word_value,
  output logic [IDX_W-1:0] word_index,
  output logic             valid,
  output logic             busy
);

  // state | meaning
  // IDLE  | bus released, CPU running
  // ADDR  | address on the bus, RAM registering it
  // CAPT  | RAM data valid, capture into word_value
  // SHOW  | word displayed, waiting for next/prev/exit
  typedef enum logic [1:0] {IDLE, ADDR, CAPT, SHOW} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
  localparam logic [31:0]      LAST_ADDR = BASE_ADDR + 32'(4 * (N_WORDS - 1));

  // Bit order {exit, prev, next, start}; sync3 is the edge detector's history.
  logic [3:0] sync1_q, sync2_q, sync3_q, btn_p;
  logic       start_p, next_p, prev_p, exit_p;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= {exit_btn, prev_btn, next_btn, start_btn};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign btn_p   = sync2_q & ~sync3_q;
  assign start_p = btn_p[0];
  assign next_p  = btn_p[1];
  assign prev_p  = btn_p[2];
  assign exit_p  = btn_p[3];

  state_t           state_q, state_d;
  logic             bus_enable_q, bus_enable_d;
  logic             cpu_enable_q, cpu_enable_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      word_value_q, word_value_d;
  logic [IDX_W-1:0] word_index_q, word_index_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             tick;

`ifdef AUTO_SCAN_EN
  // Down-counter reloaded whenever SHOW is entered or a button moves the window.
  logic [31:0] scan_q, scan_d;
  assign tick = (state_q == SHOW) && (scan_q == 32'd0);

  always_comb begin
    scan_d = 32'(SCAN_TICKS - 1);
    if (state_q == SHOW && state_d == SHOW && !(next_p || prev_p))
      scan_d = scan_q - 32'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) scan_q <= 32'(SCAN_TICKS - 1);
    else       scan_q <= scan_d;
  end
`else
  assign tick = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bus_enable_d = bus_enable_q;
    cpu_enable_d = cpu_enable_q;
    mem_addr_d   = mem_addr_q;
    word_value_d = word_value_q;
    word_index_d = word_index_q;
    valid_d      = valid_q;
    if (state_q != IDLE && exit_p) begin
      state_d      = IDLE;
      bus_enable_d = 1'b0;
      cpu_enable_d = 1'b1;
      valid_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start_p) begin
          state_d      = ADDR;
          word_index_d = '0;
          mem_addr_d   = BASE_ADDR;
          bus_enable_d = 1'b1;
          cpu_enable_d = 1'b0;
          valid_d      = 1'b0;
        end
        ADDR: state_d = CAPT;
        CAPT: begin
          word_value_d = mem_data_in;
          valid_d      = 1'b1;
          state_d      = SHOW;
        end
        SHOW: begin
          // Simultaneous next+prev cancel; the scan tick only counts when no button fires.
          if ((next_p && !prev_p) || (tick && !next_p && !prev_p)) begin
            state_d = ADDR;
            valid_d = 1'b0;
            if (word_index_q == LAST_IDX) begin
              word_index_d = '0;
              mem_addr_d   = BASE_ADDR;
            end else begin
              word_index_d = word_index_q + IDX_W'(1);
              mem_addr_d   = mem_addr_q + 32'd4;
            end
          end else if (prev_p && !next_p) begin
            state_d = ADDR;
            valid_d = 1'b0;
            if (word_index_q == '0) begin
              word_index_d = LAST_IDX;
              mem_addr_d   = LAST_ADDR;
            end else begin
              word_index_d = word_index_q - IDX_W'(1);
              mem_addr_d   = mem_addr_q - 32'd4;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      bus_enable_q <= 1'b0;
      cpu_enable_q <= 1'b1;
      mem_addr_q   <= BASE_ADDR;
      word_value_q <= '0;
      word_index_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_enable_q <= bus_enable_d;
      cpu_enable_q <= cpu_enable_d;
      mem_addr_q   <= mem_addr_d;
      word_value_q <= word_value_d;
      word_index_q <= word_index_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus_enable = bus_enable_q;
  assign cpu_enable = cpu_enable_q;
  assign mem_addr   = mem_addr_q;
  assign word_value = word_value_q;
  assign word_index = word_index_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_readback.sv
// Directed + randomized bench for mem_readback against a synchronous RAM model and an index/address reference.
module tb_mem_readback;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          NW   = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start_btn = 1'b0, next_btn = 1'b0, prev_btn = 1'b0, exit_btn = 1'b0;
  logic [31:0] mem_data_in;
  logic        bus_enable, cpu_enable, valid, busy;
  logic [31:0] mem_addr, word_value;
  logic [7:0]  word_index;

  logic [31:0] ram [0:1023];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;
  logic [31:0] exp_val;

`ifdef AUTO_SCAN_EN
  mem_readback #(.BASE_ADDR(BASE), .N_WORDS(NW), .IDX_W(8), .SCAN_TICKS(8)) dut (
`else
  mem_readback #(.BASE_ADDR(BASE), .N_WORDS(NW), .IDX_W(8)) dut (
`endif
    .clk(clk), .nrst(nrst), .start_btn(start_btn), .next_btn(next_btn),
    .prev_btn(prev_btn), .exit_btn(exit_btn), .mem_data_in(mem_data_in),
    .bus_enable(bus_enable), .mem_addr(mem_addr), .cpu_enable(cpu_enable),
    .word_value(word_value), .word_index(word_index), .valid(valid), .busy(busy));

  always #5 clk = ~clk;

  // Synchronous-read RAM: data follows the address by one clock.
  always @(posedge clk) mem_data_in <= ram[mem_addr[11:2]];

  function automatic logic [31:0] ref_addr(input int i);
    return BASE + 32'(4 * i);
  endfunction

  function automatic logic [31:0] ref_word(input int i);
    return ram[(BASE >> 2) + 32'(i)];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_word(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_idx"}, 32'(word_index), 32'(exp_idx));
    chk({tag, "_addr"}, mem_addr, ref_addr(exp_idx));
    chk({tag, "_word"}, word_value, ref_word(exp_idx));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bus"}, 32'(bus_enable), 32'd0);
    chk({tag, "_addr"}, mem_addr, BASE);
    chk({tag, "_cpu"}, 32'(cpu_enable), 32'd1);
    chk({tag, "_word"}, word_value, 32'd0);
    chk({tag, "_idx"}, 32'(word_index), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Press start from IDLE; 2 sync stages put the pulse 2 cycles after the press.
  task automatic do_start(input bit release_after);
    start_btn = 1'b1;
    cyc(2);
    chk("start_bus_pre", 32'(bus_enable), 32'd0);
    chk("start_cpu_pre", 32'(cpu_enable), 32'd1);
    cyc(1);
    chk("start_bus", 32'(bus_enable), 32'd1);
    chk("start_cpu", 32'(cpu_enable), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid0", 32'(valid), 32'd0);
    cyc(1);
    chk("start_valid1", 32'(valid), 32'd0);
    cyc(1);
    exp_idx = 0;
    chk_word("start");
    start_btn = 1'b0;
    if (release_after) cyc(3);
  endtask

  task automatic step(input int dir);
    if (dir > 0) next_btn = 1'b1;
    else         prev_btn = 1'b1;
    cyc(2);
    chk("step_pre_valid", 32'(valid), 32'd1);
    cyc(1);
    chk("step_drop0", 32'(valid), 32'd0);
    cyc(1);
    chk("step_drop1", 32'(valid), 32'd0);
    cyc(1);
    exp_idx = (exp_idx + dir + NW) % NW;
    chk_word(dir > 0 ? "next" : "prev");
    next_btn = 1'b0;
    prev_btn = 1'b0;
    cyc(3);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = $urandom();
    for (int i = 0; i < NW; i++) ram[256 + i] = 32'hA500_0000 + 32'(i);

    cyc(2);
    chk_reset_vals("reset");
    nrst = 1'b1;
    cyc(2);

`ifndef AUTO_SCAN_EN
    do_start(1'b1);
    for (int k = 0; k < 3; k++) step(1);
    chk("idx3_addr", mem_addr, 32'h0000_040C);
    chk("idx3_word", word_value, 32'hA500_0003);
    for (int k = 0; k < 3; k++) step(-1);
    step(-1);
    chk("wrap_lo_addr", mem_addr, 32'h0000_043C);
    chk("wrap_lo_word", word_value, 32'hA500_000F);
    step(1);
    chk("wrap_hi_addr", mem_addr, 32'h0000_0400);

    // next and prev together cancel out
    next_btn = 1'b1;
    prev_btn = 1'b1;
    cyc(3);
    chk("both_mid_valid", 32'(valid), 32'd1);
    cyc(3);
    chk_word("both");
    next_btn = 1'b0;
    prev_btn = 1'b0;
    cyc(3);

    next_btn = 1'b1;
    cyc(100);
    next_btn = 1'b0;
    cyc(3);
    exp_idx = (exp_idx + 1) % NW;
    chk_word("held");

    start_btn = 1'b1;
    cyc(6);
    chk_word("start_in_show");
    start_btn = 1'b0;
    cyc(3);

    for (int k = 0; k < 24; k++) step(($urandom_range(0, 1) == 1) ? 1 : -1);

    exit_btn = 1'b1;
    cyc(2);
    chk("exit_pre_busy", 32'(busy), 32'd1);
    cyc(1);
    exp_val = ref_word(exp_idx);
    chk("exit_bus", 32'(bus_enable), 32'd0);
    chk("exit_cpu", 32'(cpu_enable), 32'd1);
    chk("exit_valid", 32'(valid), 32'd0);
    chk("exit_busy", 32'(busy), 32'd0);
    chk("exit_word", word_value, exp_val);
    chk("exit_idx", 32'(word_index), 32'(exp_idx));
    exit_btn = 1'b0;
    cyc(3);

    // exit pulse lands while the FSM is in ADDR
    start_btn = 1'b1;
    cyc(1);
    exit_btn = 1'b1;
    cyc(2);
    chk("abort_in_addr_bus", 32'(bus_enable), 32'd1);
    cyc(1);
    chk("abort_bus", 32'(bus_enable), 32'd0);
    chk("abort_cpu", 32'(cpu_enable), 32'd1);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_word", word_value, exp_val);
    chk("abort_idx", 32'(word_index), 32'd0);
    start_btn = 1'b0;
    exit_btn = 1'b0;
    cyc(4);
    chk("abort_no_capture", 32'(valid), 32'd0);

    do_start(1'b1);
    step(1);
    #2 nrst = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    nrst = 1'b1;
    cyc(2);
    do_start(1'b1);
`else
    do_start(1'b0);
    for (int p = 0; p < 17; p++) begin
      cyc(7);
      chk("scan_hold", 32'(valid), 32'd1);
      cyc(1);
      chk("scan_drop", 32'(valid), 32'd0);
      cyc(2);
      exp_idx = (exp_idx + 1) % NW;
      chk_word("scan");
    end
    cyc(3);
    next_btn = 1'b1;
    cyc(2);
    chk("scan_tick5_valid", 32'(valid), 32'd1);
    cyc(1);
    chk("scan_tick5_drop", 32'(valid), 32'd0);
    cyc(2);
    exp_idx = (exp_idx + 1) % NW;
    chk_word("scan_btn");
    next_btn = 1'b0;
    cyc(7);
    chk("scan_restart_hold", 32'(valid), 32'd1);
    cyc(1);
    chk("scan_restart_drop", 32'(valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
